// File: rtl/lvds_input_axi_write.sv
// AXI4-Lite write slave owning the lvds_input CR/DSIZE registers and the SR.PC clear pulse.
// Latency: AW+W handshaked at edge N -> registers, sr_pc_clr and BVALID change at edge N+1.
// Backpressure: one write in flight; AWREADY/WREADY stay low until BREADY retires the response.
//
// Ports:
//   ACLK, ARESETN            clock (posedge) and asynchronous active-low reset
//   AWADDR/AWVALID/AWREADY   write address channel, only AWADDR[7:0] decoded
//   WDATA/WSTRB/WVALID/WREADY write data channel
//   BRESP/BVALID/BREADY      write response channel (00 OKAY, 10 SLVERR)
//   dsize                    capture size in bytes (word aligned, clamped to DSIZE_MAX)
//   cr_test, cr_rt, cr_ls    CR[0], CR[1], CR[2]
//   sr_pc_clr                single-cycle pulse requesting SR.PC clear
//
// Build option: define LVDS_INPUT_AXI_WSTRB_EN to honour WSTRB byte lanes; when
// undefined every write is a full 32-bit word and WSTRB is ignored.

module lvds_input_axi_write #(
  parameter logic [31:0] DSIZE_RST = 32'd4096,
  parameter logic [31:0] DSIZE_MAX = 32'h00FFFFFC
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [31:0] AWADDR,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  input  logic        WVALID,
  output logic        WREADY,
  output logic [1:0]  BRESP,
  output logic        BVALID,
  input  logic        BREADY,
  output logic [31:0] dsize,
  output logic        cr_test,
  output logic        cr_rt,
  output logic        cr_ls,
  output logic        sr_pc_clr
);

  localparam logic [7:0] ADDR_CR    = 8'h00;
  localparam logic [7:0] ADDR_SR    = 8'h04;
  localparam logic [7:0] ADDR_DSIZE = 8'h08;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_W,
    S_WAIT_AW,
    S_WRITE,
    S_RESP
  } state_t;

  state_t      state;
  logic [7:0]  addr_q;
  logic [31:0] data_q;

  // Handshakes use the registered READY flops, so an incoming VALID never
  // reaches READY combinationally.
  logic aw_hs;
  logic w_hs;
  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;

`ifdef LVDS_INPUT_AXI_WSTRB_EN
  logic [3:0] strb_q;
  logic       unused_bits;
  assign unused_bits = ^AWADDR[31:8];
`else
  logic unused_bits;
  assign unused_bits = ^{AWADDR[31:8], WSTRB};
`endif

  // Effect of the latched write, evaluated while in WRITE.
  logic [3:0]  strb_eff;
  logic        addr_hit;
  logic [2:0]  cr_next;
  logic [31:0] ds_merged;
  logic [31:0] ds_aligned;
  logic [31:0] ds_next;
  logic        pc_req;

  always_comb begin
`ifdef LVDS_INPUT_AXI_WSTRB_EN
    strb_eff = strb_q;
`else
    strb_eff = 4'hF;
`endif
    addr_hit = (addr_q == ADDR_CR) || (addr_q == ADDR_SR) || (addr_q == ADDR_DSIZE);

    // CR lives entirely in byte lane 0.
    cr_next = strb_eff[0] ? data_q[2:0] : {cr_ls, cr_rt, cr_test};

    // Merge enabled lanes over the current value first, then align and clamp
    // the merged word so a partial write can never leave dsize out of range.
    ds_merged = dsize;
    for (int b = 0; b < 4; b++) begin
      if (strb_eff[b]) begin
        ds_merged[8*b +: 8] = data_q[8*b +: 8];
      end
    end
    ds_aligned = {ds_merged[31:2], 2'b00};
    ds_next    = (ds_aligned > DSIZE_MAX) ? DSIZE_MAX : ds_aligned;

    pc_req = data_q[0] & strb_eff[0];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
`ifdef LVDS_INPUT_AXI_WSTRB_EN
      strb_q    <= '0;
`endif
      AWREADY   <= 1'b0;
      WREADY    <= 1'b0;
      BVALID    <= 1'b0;
      BRESP     <= RESP_OKAY;
      dsize     <= DSIZE_RST;
      cr_test   <= 1'b0;
      cr_rt     <= 1'b0;
      cr_ls     <= 1'b0;
      sr_pc_clr <= 1'b0;
    end else begin
      // Pulse is only ever set on the WRITE -> RESP edge.
      sr_pc_clr <= 1'b0;

      case (state)
        S_IDLE: begin
          if (aw_hs) begin
            addr_q <= AWADDR[7:0];
          end
          if (w_hs) begin
            data_q <= WDATA;
`ifdef LVDS_INPUT_AXI_WSTRB_EN
            strb_q <= WSTRB;
`endif
          end
          if (aw_hs && w_hs) begin
            state   <= S_WRITE;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
          end else if (aw_hs) begin
            state   <= S_WAIT_W;
            AWREADY <= 1'b0;
            WREADY  <= 1'b1;
          end else if (w_hs) begin
            state   <= S_WAIT_AW;
            AWREADY <= 1'b1;
            WREADY  <= 1'b0;
          end else begin
            // Also raises READY on the first cycle after reset release.
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
          end
        end

        S_WAIT_W: begin
          AWREADY <= 1'b0;
          if (w_hs) begin
            data_q <= WDATA;
`ifdef LVDS_INPUT_AXI_WSTRB_EN
            strb_q <= WSTRB;
`endif
            state  <= S_WRITE;
            WREADY <= 1'b0;
          end else begin
            WREADY <= 1'b1;
          end
        end

        S_WAIT_AW: begin
          WREADY <= 1'b0;
          if (aw_hs) begin
            addr_q  <= AWADDR[7:0];
            state   <= S_WRITE;
            AWREADY <= 1'b0;
          end else begin
            AWREADY <= 1'b1;
          end
        end

        S_WRITE: begin
          AWREADY <= 1'b0;
          WREADY  <= 1'b0;
          case (addr_q)
            ADDR_CR: begin
              cr_test <= cr_next[0];
              cr_rt   <= cr_next[1];
              cr_ls   <= cr_next[2];
            end
            ADDR_SR: begin
              sr_pc_clr <= pc_req;
            end
            ADDR_DSIZE: begin
              dsize <= ds_next;
            end
            default: begin
            end
          endcase
          BRESP  <= addr_hit ? RESP_OKAY : RESP_SLVERR;
          BVALID <= 1'b1;
          state  <= S_RESP;
        end

        S_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            state   <= S_IDLE;
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
          end else begin
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
          end
        end

        default: begin
          state   <= S_IDLE;
          AWREADY <= 1'b0;
          WREADY  <= 1'b0;
          BVALID  <= 1'b0;
        end
      endcase
    end
  end

endmodule
